// File: rtl/nand_dff_bank_ctrl.sv
// nand_dff_bank_ctrl: round-robin command sequencer driving a shared-control NAND DFF bank with readback check
module nand_dff_bank_ctrl #(
    parameter int WIDTH   = 8,
    parameter int SETUP   = 2,
    parameter int CK_HIGH = 2,
    parameter int HOLD    = 1,
    parameter int PULSE   = 2
) (
    input  logic             ck,
    input  logic             clr,
    input  logic             req_a_valid,
    input  logic [1:0]       req_a_op,
    input  logic [WIDTH-1:0] req_a_data,
    output logic             req_a_ready,
    input  logic             req_b_valid,
    input  logic [1:0]       req_b_op,
    input  logic [WIDTH-1:0] req_b_data,
    output logic             req_b_ready,
    output logic [WIDTH-1:0] ff_d,
    output logic             ff_ck,
    output logic             ff_pr,
    output logic             ff_clr,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic             done_src,
    output logic             done_err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_CKHI  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_PULSE = 3'd4;
    localparam logic [2:0] S_RECOV = 3'd5;
    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_PRE  = 2'b10;

    logic [2:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             src_q, src_d;
    logic             last_b_q, last_b_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ff_d_q, ff_d_d;
    logic             ff_ck_q, ff_ck_d;
    logic             ff_pr_q, ff_pr_d;
    logic             ff_clr_q, ff_clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_src_q, done_src_d;
    logic             done_err_q, done_err_d;

    logic             idle, grant_a, grant_b, accept, last_cnt;
    logic [1:0]       acc_op;
    logic [WIDTH-1:0] acc_data, exp_q;

    // Ties go to whoever was not granted last; a lone requester always wins
    assign idle        = state_q == S_IDLE;
    assign grant_a     = req_a_valid && (!req_b_valid || last_b_q);
    assign grant_b     = req_b_valid && (!req_a_valid || !last_b_q);
    assign req_a_ready = idle && grant_a;
    assign req_b_ready = idle && grant_b;
    assign accept      = req_a_ready || req_b_ready;
    assign acc_op      = grant_a ? req_a_op : req_b_op;
    assign acc_data    = grant_a ? req_a_data : req_b_data;
    assign last_cnt    = cnt_q == 8'd0;
    // For writes the expected readback is the data still held on ff_d
    assign exp_q       = op_q == OP_CLR ? '0 : op_q == OP_PRE ? '1 : ff_d_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q - 8'd1;
        op_d       = op_q;
        src_d      = src_q;
        last_b_d   = last_b_q;
        err_d      = err_q;
        ff_d_d     = ff_d_q;
        ff_ck_d    = ff_ck_q;
        ff_pr_d    = ff_pr_q;
        ff_clr_d   = ff_clr_q;
        done_d     = 1'b0;
        done_src_d = done_src_q;
        done_err_d = done_err_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d     = acc_op;
                src_d    = grant_b;
                last_b_d = grant_b;
                case (acc_op)
                    OP_WR: begin
                        state_d = S_SETUP;
                        ff_d_d  = acc_data;
                        cnt_d   = 8'(SETUP - 1);
                    end
                    OP_CLR: begin
                        state_d  = S_PULSE;
                        ff_clr_d = 1'b0;
                        cnt_d    = 8'(PULSE - 1);
                    end
                    OP_PRE: begin
                        state_d = S_PULSE;
                        ff_pr_d = 1'b0;
                        cnt_d   = 8'(PULSE - 1);
                    end
                    default: begin
                        done_d     = 1'b1;
                        done_src_d = grant_b;
                        done_err_d = 1'b1;
                    end
                endcase
            end
            S_SETUP: if (last_cnt) begin
                state_d = S_CKHI;
                ff_ck_d = 1'b1;
                cnt_d   = 8'(CK_HIGH - 1);
            end
            S_CKHI: if (last_cnt) begin
                state_d = S_HOLD;
                ff_ck_d = 1'b0;
                cnt_d   = 8'(HOLD - 1);
            end
            S_HOLD: if (last_cnt) begin
                state_d    = S_IDLE;
                done_d     = 1'b1;
                done_src_d = src_q;
                done_err_d = q_in != exp_q;
            end
            S_PULSE: if (last_cnt) begin
                state_d  = S_RECOV;
                ff_pr_d  = 1'b1;
                ff_clr_d = 1'b1;
                err_d    = q_in != exp_q;
            end
            S_RECOV: begin
                state_d    = S_IDLE;
                done_d     = 1'b1;
                done_src_d = src_q;
                done_err_d = err_q;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge ck or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            op_q       <= OP_WR;
            src_q      <= 1'b0;
            last_b_q   <= 1'b1;
            err_q      <= 1'b0;
            ff_d_q     <= '0;
            ff_ck_q    <= 1'b0;
            ff_pr_q    <= 1'b1;
            ff_clr_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_src_q <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            src_q      <= src_d;
            last_b_q   <= last_b_d;
            err_q      <= err_d;
            ff_d_q     <= ff_d_d;
            ff_ck_q    <= ff_ck_d;
            ff_pr_q    <= ff_pr_d;
            ff_clr_q   <= ff_clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_src_q <= done_src_d;
            done_err_q <= done_err_d;
        end
    end

    assign ff_d     = ff_d_q;
    assign ff_ck    = ff_ck_q;
    assign ff_pr    = ff_pr_q;
    assign ff_clr   = ff_clr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign done_src = done_src_q;
    assign done_err = done_err_q;
endmodule

// File: tb/tb_nand_dff_bank_ctrl.sv
// tb_nand_dff_bank_ctrl: vector table, reset-abort sequence and random commands against a timing-rule model
module tb_nand_dff_bank_ctrl;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int CH = 2;
    localparam int HO = 1;
    localparam int P  = 2;

    logic         ck = 1'b0, clr = 1'b0;
    logic         req_a_valid = 1'b0, req_b_valid = 1'b0;
    logic [1:0]   req_a_op = 2'b00, req_b_op = 2'b00;
    logic [W-1:0] req_a_data = '0, req_b_data = '0;
    logic         req_a_ready, req_b_ready;
    logic [W-1:0] ff_d, q_in;
    logic         ff_ck, ff_pr, ff_clr, busy, done, done_src, done_err;

    logic [W-1:0] bank = '0, ov_val = '0;
    logic         ov_en = 1'b0;
    int           n_chk = 0, n_fail = 0;
    logic         last_b = 1'b1;
    logic [W-1:0] last_d = '0;

    typedef struct {
        logic         src;
        logic [1:0]   op;
        logic [W-1:0] data;
        logic         ov_en;
        logic [W-1:0] ov_val;
        logic         both;
        logic         exp_err;
    } vec_t;

    vec_t tbl[10];

    nand_dff_bank_ctrl #(.WIDTH(W), .SETUP(S), .CK_HIGH(CH), .HOLD(HO), .PULSE(P)) dut (
        .ck(ck), .clr(clr),
        .req_a_valid(req_a_valid), .req_a_op(req_a_op), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
        .req_b_valid(req_b_valid), .req_b_op(req_b_op), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
        .ff_d(ff_d), .ff_ck(ff_ck), .ff_pr(ff_pr), .ff_clr(ff_clr), .q_in(q_in),
        .busy(busy), .done(done), .done_src(done_src), .done_err(done_err)
    );

    always #5 ck = ~ck;

    // Behavioural bank: async active-low clear/preset, rising-edge capture
    always @(posedge ff_ck or negedge ff_clr or negedge ff_pr)
        if (!ff_clr) bank <= '0;
        else if (!ff_pr) bank <= '1;
        else bank <= ff_d;
    assign q_in = ov_en ? ov_val : bank;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] want_q(input logic [1:0] op, input logic [W-1:0] data);
        return op == 2'd0 ? data : op == 2'd1 ? '0 : '1;
    endfunction

    function automatic logic calc_err(input logic [1:0] op, input logic [W-1:0] data,
                                      input logic oe, input logic [W-1:0] ov);
        return op == 2'd3 ? 1'b1 : ((oe ? ov : want_q(op, data)) != want_q(op, data));
    endfunction

    function automatic int op_len(input logic [1:0] op);
        return op == 2'd0 ? S + CH + HO + 1 : op == 2'd3 ? 1 : P + 2;
    endfunction

    task automatic run_op(input vec_t v);
        int           len;
        logic [W-1:0] exp_d;
        @(negedge ck);
        ov_en  = v.ov_en;
        ov_val = v.ov_val;
        if (v.src == 1'b0 || v.both) begin
            req_a_valid = 1'b1;
            req_a_op    = v.src ? 2'd0 : v.op;
            req_a_data  = v.src ? ~v.data : v.data;
        end
        if (v.src == 1'b1 || v.both) begin
            req_b_valid = 1'b1;
            req_b_op    = v.src ? v.op : 2'd0;
            req_b_data  = v.src ? v.data : ~v.data;
        end
        #1;
        chk($sformatf("ready_a src%0d both%0d", v.src, v.both), req_a_ready, v.src == 1'b0);
        chk($sformatf("ready_b src%0d both%0d", v.src, v.both), req_b_ready, v.src == 1'b1);
        last_b = v.src;
        exp_d  = v.op == 2'd0 ? v.data : last_d;
        len    = op_len(v.op);
        for (int k = 1; k <= len; k++) begin
            @(negedge ck);
            if (k == 1) begin
                req_a_valid = 1'b0;
                req_b_valid = 1'b0;
            end
            chk($sformatf("op%0d k%0d done", v.op, k), done, k == len);
            chk($sformatf("op%0d k%0d busy", v.op, k), busy, k < len);
            chk($sformatf("op%0d k%0d ff_ck", v.op, k), ff_ck, v.op == 2'd0 && k > S && k <= S + CH);
            chk($sformatf("op%0d k%0d ff_clr", v.op, k), ff_clr, !(v.op == 2'd1 && k <= P));
            chk($sformatf("op%0d k%0d ff_pr", v.op, k), ff_pr, !(v.op == 2'd2 && k <= P));
            chk($sformatf("op%0d k%0d ff_d", v.op, k), ff_d, exp_d);
            if (k == len) begin
                chk($sformatf("op%0d done_src", v.op), done_src, v.src);
                chk($sformatf("op%0d done_err", v.op), done_err, v.exp_err);
            end
        end
        last_d = exp_d;
        ov_en  = 1'b0;
    endtask

    // Protocol checker over every cycle out of reset
    logic [W-1:0] prev_d = '0;
    logic         prev_busy = 1'b0;
    always @(negedge ck) begin
        if (clr) begin
            chk("pr_and_clr_both_low", ff_pr | ff_clr, 1);
            chk("ck_high_during_pulse", ff_ck && !(ff_pr && ff_clr), 0);
            chk("ff_d_changed_outside_setup_entry", (ff_d != prev_d) && !(busy && !prev_busy), 0);
        end
        prev_d    = ff_d;
        prev_busy = busy;
    end

    initial begin
        vec_t         v;
        logic [W-1:0] w;
        tbl[0] = '{1'b0, 2'd0, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 2'd0, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 2'd1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 2'd2, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 2'd0, 8'h3C, 1'b1, 8'h3D, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 2'd3, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 2'd2, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 2'd0, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0};

        repeat (3) @(negedge ck);
        chk("rst ff_d", ff_d, 0);
        chk("rst ff_ck", ff_ck, 0);
        chk("rst ff_pr", ff_pr, 1);
        chk("rst ff_clr", ff_clr, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst done_src", done_src, 0);
        chk("rst done_err", done_err, 0);
        chk("rst ready_a", req_a_ready, 0);
        chk("rst ready_b", req_b_ready, 0);
        clr = 1'b1;

        for (int i = 0; i < 10; i++) run_op(tbl[i]);

        // Reset mid-write while ff_ck is high
        @(negedge ck);
        req_a_valid = 1'b1;
        req_a_op    = 2'd0;
        req_a_data  = 8'h5A;
        #1;
        chk("abort ready_a", req_a_ready, 1);
        repeat (S + 1) @(negedge ck);
        chk("abort ckhi ff_ck", ff_ck, 1);
        #2;
        clr = 1'b0;
        #1;
        chk("abort ff_ck", ff_ck, 0);
        chk("abort ff_d", ff_d, 0);
        chk("abort busy", busy, 0);
        chk("abort ff_pr", ff_pr, 1);
        chk("abort ff_clr", ff_clr, 1);
        req_a_valid = 1'b0;
        repeat (2) begin
            @(negedge ck);
            chk("abort no done", done, 0);
        end
        clr    = 1'b1;
        last_b = 1'b1;
        last_d = '0;
        v = '{1'b0, 2'd0, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
        run_op(v);

        for (int i = 0; i < 60; i++) begin
            v.both   = $urandom_range(0, 3) == 0;
            v.src    = v.both ? !last_b : 1'($urandom_range(0, 1));
            v.op     = 2'($urandom_range(0, 3));
            v.data   = W'($urandom);
            w        = want_q(v.op, v.data);
            v.ov_en  = $urandom_range(0, 2) == 0;
            v.ov_val = $urandom_range(0, 1) ? w : W'($urandom);
            v.exp_err = calc_err(v.op, v.data, v.ov_en, v.ov_val);
            run_op(v);
        end

        repeat (2) @(negedge ck);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
